// File: rtl/shift_iter.sv
// Multi-cycle iterative RV32 shift unit (SLL/SRL/SRA).
// Shifts by up to STEP bits per cycle and holds the result until it is accepted.
module shift_iter #(
    parameter int unsigned STEP = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [5:0] STEP_W = 6'(STEP);

    logic [1:0]  state_q;
    logic [31:0] acc_q;
    logic [4:0]  rem_q;
    logic        left_q;
    logic        fill_q;
    logic        err_q;

    logic [4:0]  step_n;
    logic [31:0] acc_shifted;
    logic        last_step;
    logic        supported;
    logic        accept;
    logic [4:0]  shamt;
    logic        unused_op2;

    assign shamt      = op2_i[4:0];
    assign unused_op2 = ^op2_i[31:5];
    assign supported  = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    assign accept     = req_valid_i && (state_q == IDLE) && !flush_i;

    always_comb begin
        step_n    = ({1'b0, rem_q} > STEP_W) ? STEP_W[4:0] : rem_q;
        last_step = ({1'b0, rem_q} <= STEP_W);
        // Right shifts extend a 33-bit value so one arithmetic shift covers SRL and SRA.
        if (left_q) begin
            acc_shifted = acc_q << step_n;
        end else begin
            acc_shifted = 32'($signed({fill_q, acc_q}) >>> step_n);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            fill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (flush_i && (state_q != IDLE)) begin
            state_q <= IDLE;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        left_q <= (funct3_i == 3'b001);
                        fill_q <= op1_i[31] && (funct3_i == 3'b101) && funct7_i;
                        rem_q  <= shamt;
                        err_q  <= !supported;
                        acc_q  <= supported ? op1_i : '0;
                        state_q <= (supported && (shamt != 5'd0)) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_shifted;
                    rem_q <= rem_q - step_n;
                    if (last_step) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign res_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign res_o       = acc_q;
    assign err_o       = err_q;

endmodule
